// File: rtl/simplearm_pkg.sv
// Shared types and constants for the block-transfer sequencer slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package simplearm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] REG_PC     = 4'd15;
  localparam int         WORD_BYTES = 4;

  // Number of registers named in a 16-bit list.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/blk_xfer_seq_if.sv
// Bundle of command, memory-beat and register-file signals around the sequencer.
// Latency: none (wires only).
// Backpressure: mem_ready stalls the current memory beat.
interface blk_xfer_seq_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // command, sampled at start
  logic              start;
  logic              is_load;
  logic              p_bit;
  logic              u_bit;
  logic              w_bit;
  logic [3:0]        rn;
  logic [ADDR_W-1:0] base;
  logic [15:0]       reglist;
  // memory beat handshake
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  // register file third read port and write port
  logic [3:0]        rf_ra;
  logic [DATA_W-1:0] rf_rd;
  logic              rf_we;
  logic [3:0]        rf_wa;
  logic [DATA_W-1:0] rf_wd;
  // PC redirect and status
  logic              pc_we;
  logic [DATA_W-1:0] pc_wd;
  logic              busy;
  logic              done;

  // sequencer side
  modport master (
    input  start, is_load, p_bit, u_bit, w_bit, rn, base, reglist,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output rf_ra,
    input  rf_rd,
    output rf_we, rf_wa, rf_wd, pc_we, pc_wd, busy, done
  );

  // environment side: decoder, memory and register file
  modport slave (
    output start, is_load, p_bit, u_bit, w_bit, rn, base, reglist,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  rf_ra,
    output rf_rd,
    input  rf_we, rf_wa, rf_wd, pc_we, pc_wd, busy, done
  );

endinterface

// File: rtl/prio_enc16.sv
// Lowest-set-bit encoder over a 16-bit mask.
// Latency: combinational.
// Backpressure: none.
module prio_enc16 (
  input  logic [15:0] mask_i,
  output logic [3:0]  idx_o,
  output logic        vld_o
);

  // scan high to low so the lowest set bit is the last one assigned
  always_comb begin
    idx_o = 4'd0;
    vld_o = |mask_i;
    for (int i = 15; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/blk_xfer_seq.sv
// LDM/STM sequencer: walks the register list lowest index first, one memory beat per register.
// Latency: first mem_req the cycle after start; done the cycle after the last handshake.
// Backpressure: mem_ready low holds address, register index and store data stable.
module blk_xfer_seq
  import simplearm_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  blk_xfer_seq_if.master  bus
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

  state_e            state_q;
  logic [15:0]       mask_q;
  logic [15:0]       mask_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] final_q;
  logic              load_q;
  logic              wb_q;
  logic [3:0]        rn_q;

  logic [3:0]        cur;
  logic              cur_vld;
  logic              in_xfer;
  logic              in_done;
  logic              hs;

  // capture-time values derived from the command inputs
  logic [4:0]        cnt;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] final_base;
  logic              wb_cap;

  prio_enc16 u_enc (
    .mask_i (mask_q),
    .idx_o  (cur),
    .vld_o  (cur_vld)
  );

  assign in_xfer = (state_q == XFER);
  assign in_done = (state_q == DONE);
  assign hs      = in_xfer & cur_vld & bus.mem_ready;
  assign mask_d  = mask_q & ~(16'd1 << cur);

  // start address and final base for the four addressing modes; wraps mod 2^ADDR_W
  always_comb begin
    cnt        = popcount16(bus.reglist);
    span       = ADDR_W'(cnt) * STEP;
    final_base = bus.u_bit ? (bus.base + span) : (bus.base - span);
    start_addr = bus.base;
    case ({bus.p_bit, bus.u_bit})
      2'b01:   start_addr = bus.base;
      2'b11:   start_addr = bus.base + STEP;
      2'b00:   start_addr = bus.base - span + STEP;
      default: start_addr = bus.base - span;
    endcase
    // a loaded Rn beats the writeback, and R15 is never a writeback target
    wb_cap = bus.w_bit && (cnt != 5'd0) && !(bus.is_load && bus.reglist[bus.rn])
             && (bus.rn != REG_PC);
  end

  // sequencer FSM and transfer context
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      final_q <= '0;
      load_q  <= 1'b0;
      wb_q    <= 1'b0;
      rn_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mask_q  <= bus.reglist;
            addr_q  <= start_addr;
            final_q <= final_base;
            load_q  <= bus.is_load;
            wb_q    <= wb_cap;
            rn_q    <= bus.rn;
            state_q <= (cnt == 5'd0) ? DONE : XFER;
          end
        end
        XFER: begin
          if (hs) begin
            mask_q <= mask_d;
            addr_q <= addr_q + STEP;
            if (mask_d == 16'd0) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // beat outputs, load steering and writeback; everything idles at zero outside XFER/DONE
  always_comb begin
    bus.mem_req   = in_xfer & cur_vld;
    bus.mem_we    = in_xfer & ~load_q;
    bus.mem_addr  = in_xfer ? addr_q : {ADDR_W{1'b0}};
    bus.rf_ra     = in_xfer ? cur : 4'd0;
    bus.mem_wdata = in_xfer ? bus.rf_rd : {DATA_W{1'b0}};
    bus.rf_we     = 1'b0;
    bus.rf_wa     = 4'd0;
    bus.rf_wd     = {DATA_W{1'b0}};
    bus.pc_we     = 1'b0;
    bus.pc_wd     = {DATA_W{1'b0}};
    bus.busy      = in_xfer | in_done;
    bus.done      = in_done;
    if (hs && load_q) begin
      if (cur == REG_PC) begin
        bus.pc_we = 1'b1;
        bus.pc_wd = bus.mem_rdata;
      end else begin
        bus.rf_we = 1'b1;
        bus.rf_wa = cur;
        bus.rf_wd = bus.mem_rdata;
      end
    end
    if (in_done && wb_q) begin
      bus.rf_we = 1'b1;
      bus.rf_wa = rn_q;
      bus.rf_wd = DATA_W'(final_q);
    end
  end

endmodule
